// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared types, register map codes and int8 saturation for the conv engine
package npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_POST = 2'd2,
        ST_PACK = 2'd3
    } state_t;

    localparam logic [2:0] SEL_PIXEL  = 3'd1;
    localparam logic [2:0] SEL_WEIGHT = 3'd2;
    localparam logic [2:0] SEL_CTRL   = 3'd4;
    localparam logic [2:0] SEL_STATUS = 3'd5;
    localparam logic [2:0] SEL_POP    = 3'd6;
    localparam logic [2:0] SEL_PERF   = 3'd7;

    localparam int CTRL_START     = 0;
    localparam int CTRL_RELU      = 1;
    localparam int CTRL_FIFO_CLR  = 2;
    localparam int CTRL_PX_SIGNED = 3;
    localparam int CTRL_FLUSH     = 4;
    localparam int CTRL_CLR_ERR   = 5;
    localparam int CTRL_SHIFT_LSB = 8;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_DONE      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_ERR       = 4;
    localparam int STAT_COUNT_LSB = 16;

    function automatic logic [7:0] sat_int8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v > 32'sd127)
            r = 8'h7f;
        else if (v < -32'sd128)
            r = 8'h80;
        else
            r = v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// rtl/npu_sync_fifo.sv - single-clock output FIFO with occupancy count and synchronous clear
module npu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/npu_conv_engine.sv
// rtl/npu_conv_engine.sv - host-mapped KxK conv MAC engine with int8 packing FIFO; NPU_PERF_CNT_EN adds busy-cycle counter
module npu_conv_engine
    import npu_pkg::*;
#(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [31:0]       dina,
    output logic [31:0]       douta,
    output logic              busy,
    output logic              irq
);
    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_COL = 4'(K_W - 1);
    localparam logic [4:0] K_W5     = 5'(K_W);

    state_t state, state_next;

    logic [7:0]              px  [K_H][K_W];
    logic [7:0]              wt  [K_H][K_W];
    logic signed [ACC_W-1:0] acc [K_H];
    logic [3:0]              col;
    logic                    relu_en, px_signed;
    logic [4:0]              shift;
    logic                    done, err, ovf, flush_pend;
    logic [1:0]              pc;
    logic [23:0]             pack_reg;
    logic [7:0]              res_byte;

    logic [2:0]  sel;
    logic        wr_en, rd_en, px_wr, wt_wr, ctrl_wr;
    logic        start_go, fifo_clr, flush_now, pack_push, push, pop;
    logic [31:0] push_data, pop_data, status_word, perf_val;
    logic [CNT_W-1:0] count;
    logic        full, empty;
    logic        unused_bits;

    assign sel       = addra[14:12];
    assign wr_en     = ena && wea;
    assign rd_en     = ena && !wea;
    assign px_wr     = wr_en && (sel == SEL_PIXEL);
    assign wt_wr     = wr_en && (sel == SEL_WEIGHT);
    assign ctrl_wr   = wr_en && (sel == SEL_CTRL);
    assign busy      = (state != ST_IDLE);
    assign irq       = !empty;
    assign start_go  = ctrl_wr && dina[CTRL_START] && !busy;
    assign fifo_clr  = ctrl_wr && dina[CTRL_FIFO_CLR];
    assign flush_now = (state == ST_IDLE) && (flush_pend || (ctrl_wr && dina[CTRL_FLUSH]));
    assign pack_push = (state == ST_PACK) && (pc == 2'd3);
    assign push      = pack_push || (flush_now && (pc != 2'd0));
    // Bytes above pc are kept zero, so a flushed partial word is already padded
    assign push_data = pack_push ? {res_byte, pack_reg} : {8'h00, pack_reg};
    assign pop       = rd_en && (sel == SEL_POP) && !empty;
    assign unused_bits = ^{dina, addra};

    assign status_word = {8'h00, 8'(count), 11'h000, err, ovf, done, full, empty};

    npu_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K_H; r++)
                for (int c = 0; c < K_W; c++) begin
                    px[r][c] <= '0;
                    wt[r][c] <= '0;
                end
        end else if (!busy) begin
            if (px_wr)
                for (int r = 0; r < K_H; r++) begin
                    for (int c = 0; c < K_W - 1; c++)
                        px[r][c] <= px[r][c+1];
                    px[r][K_W-1] <= dina[8*r +: 8];
                end
            if (wt_wr && ({1'b0, addra[3:0]} < K_W5))
                for (int r = 0; r < K_H; r++)
                    for (int c = 0; c < K_W; c++)
                        if (addra[3:0] == 4'(c))
                            wt[r][c] <= dina[8*r +: 8];
        end
    end

    logic [7:0]              cur_px [K_H];
    logic [7:0]              cur_wt [K_H];
    logic [8:0]              px9    [K_H];
    logic signed [ACC_W-1:0] prod   [K_H];

    always_comb begin
        for (int r = 0; r < K_H; r++) begin
            cur_px[r] = 8'h00;
            cur_wt[r] = 8'h00;
            for (int c = 0; c < K_W; c++)
                if (col == 4'(c)) begin
                    cur_px[r] = px[r][c];
                    cur_wt[r] = wt[r][c];
                end
            px9[r]  = {px_signed & cur_px[r][7], cur_px[r]};
            prod[r] = ACC_W'($signed(px9[r]) * $signed(cur_wt[r]));
        end
    end

    logic signed [ACC_W-1:0] sum, shifted;
    logic signed [31:0]      v32;

    always_comb begin
        sum = '0;
        for (int r = 0; r < K_H; r++)
            sum = sum + acc[r];
        shifted = sum >>> shift;
        if (relu_en && (shifted < 0))
            shifted = '0;
        v32 = 32'(shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_go) state_next = ST_MAC;
            ST_MAC:  if (col == LAST_COL) state_next = ST_POST;
            ST_POST: state_next = ST_PACK;
            ST_PACK: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K_H; r++)
                acc[r] <= '0;
            col        <= '0;
            relu_en    <= 1'b0;
            px_signed  <= 1'b0;
            shift      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            flush_pend <= 1'b0;
            pc         <= '0;
            pack_reg   <= '0;
            res_byte   <= '0;
        end else begin
            if (ctrl_wr) begin
                relu_en   <= dina[CTRL_RELU];
                px_signed <= dina[CTRL_PX_SIGNED];
                shift     <= dina[CTRL_SHIFT_LSB +: 5];
            end

            if (start_go) begin
                col <= '0;
                for (int r = 0; r < K_H; r++)
                    acc[r] <= '0;
            end else if (state == ST_MAC) begin
                col <= col + 4'd1;
                for (int r = 0; r < K_H; r++)
                    acc[r] <= acc[r] + prod[r];
            end

            if (state == ST_POST)
                res_byte <= sat_int8(v32);

            if (start_go)
                done <= 1'b0;
            else if (state == ST_PACK)
                done <= 1'b1;

            if (busy && (px_wr || wt_wr))
                err <= 1'b1;
            else if (ctrl_wr && dina[CTRL_CLR_ERR])
                err <= 1'b0;

            if (fifo_clr)
                ovf <= 1'b0;
            else if (push && full && !pop)
                ovf <= 1'b1;

            // A flush requested mid-window waits until the window's byte is packed
            if (ctrl_wr && dina[CTRL_FLUSH] && busy)
                flush_pend <= 1'b1;
            else if (flush_now)
                flush_pend <= 1'b0;

            if (fifo_clr) begin
                pc       <= '0;
                pack_reg <= '0;
            end else if (state == ST_PACK) begin
                if (pc == 2'd3) begin
                    pc       <= '0;
                    pack_reg <= '0;
                end else begin
                    pack_reg[8*pc +: 8] <= res_byte;
                    pc                  <= pc + 2'd1;
                end
            end else if (flush_now) begin
                pc       <= '0;
                pack_reg <= '0;
            end
        end
    end

`ifdef NPU_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_cnt <= '0;
        else if (ctrl_wr && dina[CTRL_START] && dina[CTRL_CLR_ERR])
            perf_cnt <= '0;
        else if (busy && (perf_cnt != 32'hffff_ffff))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_val = perf_cnt;
`else
    assign perf_val = 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            douta <= '0;
        else if (rd_en) begin
            case (sel)
                SEL_STATUS: douta <= status_word;
                SEL_POP:    douta <= empty ? 32'd0 : pop_data;
                SEL_PERF:   douta <= perf_val;
                default:    douta <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_conv_engine.sv
// tb/tb_npu_conv_engine.sv - scoreboard bench for npu_conv_engine with a behavioural result/packing model
module tb_npu_conv_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        busy;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb [$];
    logic [7:0]  tb_px [3][3];
    logic [7:0]  tb_w  [3][3];
    logic [31:0] m_pack;
    int          m_pc;
    bit          m_done, m_err, m_ovf;

    always #5 clk = ~clk;

    npu_conv_engine dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .busy  (busy),
        .irq   (irq)
    );

    function automatic void model_clear();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                tb_px[r][c] = 8'h00;
                tb_w[r][c]  = 8'h00;
            end
        sb.delete();
        m_pack = 32'h0;
        m_pc   = 0;
        m_done = 0;
        m_err  = 0;
        m_ovf  = 0;
    endfunction

    function automatic void model_fifo_push(input logic [31:0] w);
        if (sb.size() == 16)
            m_ovf = 1;
        else
            sb.push_back(w);
    endfunction

    function automatic void model_byte_push(input logic [7:0] b);
        m_pack[8*m_pc +: 8] = b;
        m_pc++;
        if (m_pc == 4) begin
            model_fifo_push(m_pack);
            m_pack = 32'h0;
            m_pc   = 0;
        end
    endfunction

    function automatic void model_flush();
        if (m_pc > 0) begin
            model_fifo_push(m_pack);
            m_pack = 32'h0;
            m_pc   = 0;
        end
    endfunction

    function automatic logic [7:0] model_result(input int shamt, input bit relu, input bit psigned);
        int sum, p, w, v;
        sum = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                p = psigned ? int'($signed(tb_px[r][c])) : int'(tb_px[r][c]);
                w = int'($signed(tb_w[r][c]));
                sum += p * w;
            end
        sum = (sum <<< 8) >>> 8;
        v = sum >>> shamt;
        if (relu && v < 0) v = 0;
        if (v > 127) return 8'h7f;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic [31:0] exp_status();
        return {8'h00, 8'(sb.size()), 11'h000, m_err, m_ovf, m_done,
                sb.size() == 16, sb.size() == 0};
    endfunction

    function automatic logic [31:0] sb_next();
        if (sb.size() == 0) return 32'h0;
        return sb.pop_front();
    endfunction

    function automatic logic [31:0] ctrl_word(input bit start, input bit relu, input bit clr,
                                              input bit psigned, input bit flush, input bit clrerr,
                                              input int shamt);
        return {19'h0, 5'(shamt), 2'b00, clrerr, flush, psigned, clr, relu, start};
    endfunction

    task automatic do_write(input logic [2:0] sel, input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = {1'b0, sel, 8'h00, idx}; dina = data;
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] sel, output logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = {1'b0, sel, 12'h000};
        @(negedge clk);
        data = douta;
        ena = 1'b0;
    endtask

    task automatic load_px_col(input logic [31:0] col);
        do_write(3'd1, 4'd0, col);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++)
                tb_px[r][c] = tb_px[r][c+1];
            tb_px[r][2] = col[8*r +: 8];
        end
    endtask

    task automatic load_weights(input logic [7:0] w);
        for (int c = 0; c < 3; c++) begin
            do_write(3'd2, 4'(c), {8'h00, w, w, w});
            for (int r = 0; r < 3; r++)
                tb_w[r][c] = w;
        end
    endtask

    task automatic load_px_seq();
        load_px_col(32'h00030201);
        load_px_col(32'h00060504);
        load_px_col(32'h00090807);
    endtask

    task automatic start_window(input int shamt, input bit relu, input bit psigned);
        do_write(3'd4, 4'd0, ctrl_word(1, relu, 0, psigned, 0, 0, shamt));
        model_byte_push(model_result(shamt, relu, psigned));
        m_done = 0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cyc);
        end
        m_done = 1;
    endtask

    task automatic run_window(input int shamt, input bit relu, input bit psigned, output int cyc);
        start_window(shamt, relu, psigned);
        wait_idle(cyc);
    endtask

    task automatic do_flush();
        do_write(3'd4, 4'd0, ctrl_word(0, 0, 0, 0, 1, 0, 0));
        model_flush();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        rst = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (douta !== 32'h0) begin errors++; $display("FAIL reset_douta: got %h required 0", douta); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL reset_status: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_basic();
        logic [31:0] d, e;
        int cyc;
        load_weights(8'h01);
        load_px_seq();
        for (int i = 0; i < 4; i++) begin
            run_window(0, 0, 0, cyc);
            if (i == 0) begin
                checks++;
                if (cyc !== 5) begin errors++; $display("FAIL basic_latency: busy %0d cycles required 5", cyc); end
            end
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b required 1", irq); end
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL basic_status: got %h required %h", d, exp_status()); end
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL basic_pop: got %h required %h", d, e); end
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL basic_pop_empty: got %h required %h", d, e); end
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL basic_status_empty: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_relu();
        logic [31:0] d, e;
        int cyc;
        load_weights(8'hff);
        run_window(0, 1, 0, cyc);
        run_window(0, 0, 0, cyc);
        do_flush();
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL relu_pop: got %h required %h", d, e); end
    endtask

    task automatic test_saturate();
        logic [31:0] d, e;
        int cyc;
        for (int i = 0; i < 3; i++) load_px_col(32'h00ffffff);
        load_weights(8'h7f);
        run_window(8, 0, 0, cyc);
        run_window(16, 0, 0, cyc);
        run_window(0, 0, 1, cyc);
        do_flush();
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL saturate_pop: got %h required %h", d, e); end
    endtask

    task automatic test_flush();
        logic [31:0] d, e;
        int cyc;
        load_weights(8'h01);
        load_px_seq();
        run_window(0, 0, 0, cyc);
        do_flush();
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL flush_pop: got %h required %h", d, e); end
        do_flush();
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL flush_empty_status: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        int cyc;
        do_write(3'd4, 4'd0, ctrl_word(0, 0, 1, 0, 0, 0, 0));
        sb.delete(); m_pack = 32'h0; m_pc = 0; m_ovf = 0;
        for (int i = 0; i < 17; i++) begin
            run_window(i % 6, 0, 0, cyc);
            do_flush();
        end
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovf_status: got %h required %h", d, exp_status()); end
        for (int i = 0; i < 16; i++) begin
            do_read(3'd6, d); e = sb_next();
            checks++; if (d !== e) begin errors++; $display("FAIL ovf_pop%0d: got %h required %h", i, d, e); end
        end
        do_write(3'd4, 4'd0, ctrl_word(0, 0, 1, 0, 0, 0, 0));
        m_ovf = 0;
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovf_clr_status: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_err();
        logic [31:0] d, e;
        int cyc;
        start_window(0, 0, 0);
        do_write(3'd1, 4'd0, 32'h00ffffff);
        m_err = 1;
        wait_idle(cyc);
        run_window(0, 0, 0, cyc);
        do_flush();
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL err_status: got %h required %h", d, exp_status()); end
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL err_window_pop: got %h required %h", d, e); end
        do_write(3'd4, 4'd0, ctrl_word(0, 0, 0, 0, 0, 1, 0));
        m_err = 0;
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL err_clr_status: got %h required %h", d, exp_status()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        int cyc;
        run_window(0, 0, 0, cyc);
        do_flush();
        do_read(3'd5, d);
        start_window(0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        checks++; if (douta !== 32'h0) begin errors++; $display("FAIL rstmid_douta: got %h required 0", douta); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b required 0", irq); end
        @(negedge clk);
        rst = 1'b0;
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL rstmid_status: got %h required %h", d, exp_status()); end
        load_px_seq();
        run_window(0, 0, 0, cyc);
        do_flush();
        do_read(3'd5, d);
        checks++; if (d !== exp_status()) begin errors++; $display("FAIL rstmid_status2: got %h required %h", d, exp_status()); end
        do_read(3'd6, d); e = sb_next();
        checks++; if (d !== e) begin errors++; $display("FAIL rstmid_zero_weights: got %h required %h", d, e); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_flush();
        test_overflow();
        test_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
